// File: rtl/count_checker.sv
// Sequence checker for a free-running 128-bit up-counter: acquires lock after
// LOCK_CNT consecutive correct samples, then flags and records deviations.
module count_checker #(
  parameter int LOCK_CNT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [127:0] count_i,
  input  logic         clear_i,
  output logic         locked_o,
  output logic         err_o,
  output logic [15:0]  err_count_o,
  output logic [127:0] expected_o,
  output logic [127:0] first_bad_o,
  output logic         first_bad_valid_o
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_CNT_C = 8'(LOCK_CNT);

  state_t         state_r, state_s;
  logic [7:0]     match_cnt_r, match_cnt_s;
  logic [127:0]   expected_r, expected_s;
  logic [15:0]    err_cnt_r, err_cnt_s;
  logic [127:0]   first_bad_r, first_bad_s;
  logic           first_bad_valid_r, first_bad_valid_s;
  logic           locked_r, locked_s;
  logic           err_r, err_s;
  logic           hit_s;

  assign hit_s = (count_i == expected_r);

  // Next-state and next-output logic; cycles without valid_i hold everything.
  always_comb begin
    state_s           = state_r;
    match_cnt_s       = match_cnt_r;
    expected_s        = expected_r;
    err_cnt_s         = err_cnt_r;
    first_bad_s       = first_bad_r;
    first_bad_valid_s = first_bad_valid_r;
    err_s             = 1'b0;
    if (valid_i) begin
      case (state_r)
        ST_UNLOCKED: begin
          expected_s  = count_i + 128'd1;
          match_cnt_s = 8'd0;
          state_s     = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (hit_s) begin
            expected_s  = expected_r + 128'd1;
            match_cnt_s = match_cnt_r + 8'd1;
            if (match_cnt_s == LOCK_CNT_C) begin
              state_s = ST_LOCKED;
            end else begin
              state_s = ST_ACQUIRE;
            end
          end else begin
            // Re-seed silently: a mismatch before lock is not an error.
            expected_s  = count_i + 128'd1;
            match_cnt_s = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (hit_s) begin
            expected_s = expected_r + 128'd1;
          end else begin
            err_s       = 1'b1;
            err_cnt_s   = (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
            expected_s  = count_i + 128'd1;
            match_cnt_s = 8'd0;
            state_s     = ST_ACQUIRE;
            if (!first_bad_valid_r) begin
              first_bad_s       = count_i;
              first_bad_valid_s = 1'b1;
            end else begin
              first_bad_s       = first_bad_r;
              first_bad_valid_s = first_bad_valid_r;
            end
          end
        end
        default: begin
          state_s     = ST_UNLOCKED;
          match_cnt_s = 8'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    locked_s = (state_s == ST_LOCKED);
  end

  // State and output registers; reset outranks clear, clear outranks samples.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_r           <= ST_UNLOCKED;
      match_cnt_r       <= 8'd0;
      expected_r        <= 128'd0;
      err_cnt_r         <= 16'd0;
      first_bad_r       <= 128'd0;
      first_bad_valid_r <= 1'b0;
      locked_r          <= 1'b0;
      err_r             <= 1'b0;
    end else begin
      state_r           <= state_s;
      match_cnt_r       <= match_cnt_s;
      expected_r        <= expected_s;
      err_cnt_r         <= err_cnt_s;
      first_bad_r       <= first_bad_s;
      first_bad_valid_r <= first_bad_valid_s;
      locked_r          <= locked_s;
      err_r             <= err_s;
    end
  end

  assign locked_o          = locked_r;
  assign err_o             = err_r;
  assign err_count_o       = err_cnt_r;
  assign expected_o        = expected_r;
  assign first_bad_o       = first_bad_r;
  assign first_bad_valid_o = first_bad_valid_r;

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, giving the number of consecutive correct samples needed to lock; legal range 1..255.
REQ-002 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  count_i carries a sample this cycle.
REQ-005 SHALL have port count_i  input  128  sampled free-running up-count value.
REQ-006 SHALL have port clear_i  input  1  synchronous soft clear of state and statistics.
REQ-007 SHALL have port locked_o  output  1  checker is tracking a verified sequence.
REQ-008 SHALL have port err_o  output  1  one-cycle pulse on a sequence error.
REQ-009 SHALL have port err_count_o  output  16  saturating count of sequence errors.
REQ-010 SHALL have port expected_o  output  128  next value the checker expects.
REQ-011 SHALL have port first_bad_o  output  128  first erroneous sample since reset or clear.
REQ-012 SHALL have port first_bad_valid_o  output  1  first_bad_o holds a captured value.

Function
REQ-013 SHALL implement the states UNLOCKED, ACQUIRE and LOCKED; all outputs are registered.
REQ-014 SHALL ignore any cycle with valid_i=0: no state, counter or output change; err_o=0; no timeout.
REQ-015 In UNLOCKED, a valid sample S SHALL set expected_o=S+1, set match_cnt=0 and move to ACQUIRE.
REQ-016 In ACQUIRE, a valid sample equal to expected_o SHALL increment expected_o and match_cnt; when match_cnt reaches LOCK_CNT the state SHALL become LOCKED and locked_o=1 on the next cycle.
REQ-017 In ACQUIRE, a valid sample S not equal to expected_o SHALL set expected_o=S+1 and match_cnt=0, with no error flagged.
REQ-018 In LOCKED, a valid sample equal to expected_o SHALL increment expected_o only.
REQ-019 In LOCKED, a valid sample S not equal to expected_o SHALL, in the following cycle:
- pulse err_o=1;
- increment err_count_o;
- clear locked_o to 0;
- set expected_o=S+1 and match_cnt=0;
- move to ACQUIRE.
REQ-020 On the first error only, REQ-019 SHALL also load first_bad_o=S and set first_bad_valid_o=1; later errors leave both unchanged.
REQ-021 All increments SHALL be modulo 2^128; 128'hFFFF...FFFF followed by 0 is a correct sequence, not an error.
REQ-022 err_count_o SHALL saturate at 16'hFFFF; err_o still pulses on each further error.
REQ-023 Flag latency SHALL be exactly 1 cycle from the sampling edge; back-to-back errors in LOCKED are impossible, because the state leaves LOCKED.
REQ-024 clear_i=1 SHALL have the same effect as reset; if clear_i and valid_i are both high, clear wins and the sample is discarded.
REQ-025 A counter restart to 0 while LOCKED SHALL be treated as an ordinary sequence error.

Reset
REQ-026 On rst_i=1 at a clock edge, state SHALL become UNLOCKED and all outputs SHALL be 0: locked_o, err_o, err_count_o, expected_o, first_bad_o, first_bad_valid_o; match_cnt SHALL also be 0.
REQ-027 rst_i SHALL take priority over clear_i and valid_i; reset mid-sequence discards all tracking and statistics.

Verification
REQ-028 Lock with LOCK_CNT=4: samples 10,11,12,13,14 on consecutive cycles.
- Response: locked_o rises the cycle after sample 14.
- expected_o=15.
- err_o never asserted.
REQ-029 Error while locked: samples 10..14, then 20.
- Response: err_o=1 for one cycle; err_count_o=1; first_bad_o=20; first_bad_valid_o=1; locked_o=0; expected_o=21.
- Follow-up: 21..24 relocks; a later bad sample 99 gives err_count_o=2 with first_bad_o still 20.
REQ-030 Wrap-around: lock on 2^128-3 .. 2^128-1, then 0, 1.
- Response: no err_o; locked_o stays 1; expected_o=2.
REQ-031 Gapped valid: locked at expected 50; valid_i low for 7 cycles with garbage on count_i, then 50.
- Response: no err_o; locked_o stays 1.
REQ-032 Simultaneous events: clear_i and valid_i both high with a mismatching sample while locked.
- Response: all outputs 0, state UNLOCKED, no err_o.
- Also: rst_i asserted during ACQUIRE returns all outputs to 0.
REQ-033 Saturation: force 65 537 locked errors.
- Response: err_count_o=16'hFFFF; err_o pulses on every error.
